// File: rtl/pcpu_pkg.sv
// Shared definitions for the pseudo-CPU microprogram sequencer.
package pcpu_pkg;

    // Branch-mode field encodings
    localparam logic [1:0] BR_SEQ  = 2'b00;
    localparam logic [1:0] BR_JMP  = 2'b01;
    localparam logic [1:0] BR_JCC  = 2'b10;
    localparam logic [1:0] BR_HALT = 2'b11;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } useq_state_t;

    // Bit positions inside dp_ctrl
    localparam int DPC_SW    = 0;
    localparam int DPC_WA    = 1;
    localparam int DPC_WB    = 2;
    localparam int DPC_OP_LO = 3;

endpackage

// File: rtl/useq_store.sv
// Microprogram store: register-file memory, one sync write port, one async read port.
module useq_store #(
    parameter int P_LOG_MEMSIZE = 4,
    parameter int P_WIDTH       = 11
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [P_LOG_MEMSIZE-1:0] waddr,
    input  logic [P_WIDTH-1:0]       wdata,
    input  logic [P_LOG_MEMSIZE-1:0] raddr,
    output logic [P_WIDTH-1:0]       rdata
);

    logic [P_WIDTH-1:0] mem [0:(1 << P_LOG_MEMSIZE)-1];

    // Synchronous write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/useq_sequencer.sv
// Microprogram sequencer: fetches mem[pc], emits datapath control, picks next address.
module useq_sequencer
    import pcpu_pkg::*;
#(
    parameter int P_LOG_MEMSIZE    = 4,
    parameter int P_NUM_D_CTRLBITS = 5,
    parameter int P_NUM_C_CTRLBITS = 2,
    parameter int P_CNT_WIDTH      = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 en,
    input  logic                                                 start,
    input  logic                                                 prog_we,
    input  logic [P_LOG_MEMSIZE-1:0]                             prog_addr,
    input  logic [P_NUM_D_CTRLBITS+P_NUM_C_CTRLBITS+P_LOG_MEMSIZE-1:0] prog_data,
    input  logic                                                 cres,
    output logic [P_NUM_D_CTRLBITS-1:0]                          dp_ctrl,
    output logic                                                 busy,
    output logic                                                 done,
    output logic [P_LOG_MEMSIZE-1:0]                             pc,
    output logic [P_CNT_WIDTH-1:0]                               steps
);

    localparam int W = P_NUM_D_CTRLBITS + P_NUM_C_CTRLBITS + P_LOG_MEMSIZE;

    useq_state_t                 state;
    logic [W-1:0]                word;
    logic                        store_we;
    logic [P_NUM_D_CTRLBITS-1:0] word_d;
    logic [1:0]                  word_br;
    logic [P_LOG_MEMSIZE-1:0]    word_tgt;
    logic [P_LOG_MEMSIZE-1:0]    next_pc;

    // Writes while running are dropped so the executing program never changes under itself
    assign store_we = prog_we && (state != RUN);

    useq_store #(
        .P_LOG_MEMSIZE (P_LOG_MEMSIZE),
        .P_WIDTH       (W)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (word)
    );

    assign word_d   = word[W-1 -: P_NUM_D_CTRLBITS];
    assign word_br  = word[P_LOG_MEMSIZE +: 2];
    assign word_tgt = word[P_LOG_MEMSIZE-1:0];

    // Next-address select and datapath control for the current word
    always_comb begin
        next_pc = pc + 1'b1;
        dp_ctrl = '0;
        case (word_br)
            BR_JMP:  next_pc = word_tgt;
            BR_JCC:  if (cres) next_pc = word_tgt;
            default: ;
        endcase
        if ((state == RUN) && en && (word_br != BR_HALT)) begin
            dp_ctrl = word_d;
        end
    end

    // Control FSM with pc, step counter and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            steps <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (en && start) begin
                        state <= RUN;
                        pc    <= '0;
                        steps <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (word_br == BR_HALT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pc <= next_pc;
                            if (steps != '1) begin
                                steps <= steps + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
